// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_SAMPLE = 4'd7;
    localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_parity_calc.sv
// Parity generator over an N_DATA-bit word; o_parity is the bit a transmitter would
// append so that the frame meets the selected even (1) or odd (0) parity.
module uart_parity_calc #(
    parameter int N_DATA          = 8,
    parameter int EVEN_ODD_PARITY = 1
) (
    input  logic [N_DATA-1:0] i_data,
    output logic              o_parity
);

    assign o_parity = (EVEN_ODD_PARITY != 0) ? (^i_data) : (~^i_data);

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampled UART receiver: LSB-first data, optional raw parity bit, M_STOP stop bits.
// Define UART_RX_ERR_FLAGS_EN to add registered o_parity_err / o_frame_err outputs.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int NB_DATA         = 1,
    parameter int N_DATA          = 8,
    parameter int LOG2_N_DATA     = 4,
    parameter int PARITY_CHECK    = 1,
    parameter int EVEN_ODD_PARITY = 1,
    parameter int M_STOP          = 1,
    parameter int LOG2_M_STOP     = 1
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [NB_DATA-1:0]             i_data,
    input  logic                           i_valid,
    output logic [N_DATA+PARITY_CHECK-1:0] o_data,
    output logic                           rx_done
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    output logic                           o_parity_err,
    output logic                           o_frame_err
`endif
);

    localparam int                     NB_WORD   = N_DATA + PARITY_CHECK;
    localparam logic [LOG2_N_DATA-1:0] LAST_BIT  = LOG2_N_DATA'(N_DATA - 1);
    localparam logic [LOG2_M_STOP-1:0] LAST_STOP = LOG2_M_STOP'(M_STOP - 1);

    // Reject configurations the counters and shifter cannot represent.
    if (N_DATA < 2 || (2 ** LOG2_N_DATA) <= N_DATA) begin : g_bad_n_data
        $error("uart_rx_core: need N_DATA >= 2 and 2**LOG2_N_DATA > N_DATA");
    end
    if (M_STOP < 1 || (2 ** LOG2_M_STOP) <= M_STOP) begin : g_bad_m_stop
        $error("uart_rx_core: need M_STOP >= 1 and 2**LOG2_M_STOP > M_STOP");
    end
    if (PARITY_CHECK < 0 || PARITY_CHECK > 1 || EVEN_ODD_PARITY < 0 || EVEN_ODD_PARITY > 1) begin : g_bad_parity
        $error("uart_rx_core: PARITY_CHECK and EVEN_ODD_PARITY must be 0 or 1");
    end

    uart_state_e            state_q, state_d;
    logic [3:0]             tick_q, tick_d;
    logic [LOG2_N_DATA-1:0] bit_q, bit_d;
    logic [LOG2_M_STOP-1:0] stop_q, stop_d;
    logic [NB_WORD-1:0]     rx_word_q, rx_word_d;
    logic [NB_WORD-1:0]     o_data_q, o_data_d;
    logic                   done_q, done_d;
    logic                   line;

    assign line = i_data[0];

    // Data bits shift in from the top so the first bit ends in bit 0; parity sits above them.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        rx_word_d = rx_word_q;
        o_data_d  = o_data_q;
        done_d    = 1'b0;

        if (i_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!line) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == MID_SAMPLE) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = line ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                DATA: begin
                    if (tick_q == LAST_TICK) begin
                        tick_d                 = '0;
                        rx_word_d[N_DATA-1:0]  = {line, rx_word_q[N_DATA-1:1]};
                        bit_d                  = bit_q + LOG2_N_DATA'(1);
                        if (bit_q == LAST_BIT) begin
                            stop_d  = '0;
                            state_d = (PARITY_CHECK != 0) ? PARITY : STOP;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                PARITY: begin
                    if (tick_q == LAST_TICK) begin
                        tick_d = '0;
                        if (PARITY_CHECK != 0) begin
                            rx_word_d[NB_WORD-1] = line;
                        end
                        stop_d  = '0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                STOP: begin
                    if (tick_q == LAST_TICK) begin
                        tick_d = '0;
                        stop_d = stop_q + LOG2_M_STOP'(1);
                        if (stop_q == LAST_STOP) begin
                            o_data_d = rx_word_q;
                            done_d   = 1'b1;
                            state_d  = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            stop_q    <= '0;
            rx_word_q <= '0;
            o_data_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            rx_word_q <= rx_word_d;
            o_data_q  <= o_data_d;
            done_q    <= done_d;
        end
    end

    assign o_data  = o_data_q;
    assign rx_done = done_q;

`ifdef UART_RX_ERR_FLAGS_EN
    logic parity_exp;
    logic stop_sample;
    logic stop_bad_q, stop_bad_d;
    logic parity_err_q, parity_err_d;
    logic frame_err_q, frame_err_d;

    uart_parity_calc #(
        .N_DATA         (N_DATA),
        .EVEN_ODD_PARITY(EVEN_ODD_PARITY)
    ) u_parity_calc (
        .i_data  (rx_word_q[N_DATA-1:0]),
        .o_parity(parity_exp)
    );

    assign stop_sample = i_valid && (state_q == STOP) && (tick_q == LAST_TICK);

    // stop_bad remembers a low stop bit from earlier stop slots of the same frame.
    always_comb begin
        stop_bad_d   = stop_bad_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        if (done_d) begin
            stop_bad_d   = 1'b0;
            frame_err_d  = stop_bad_q | ~line;
            parity_err_d = (PARITY_CHECK != 0) && (rx_word_q[NB_WORD-1] != parity_exp);
        end else if (stop_sample && !line) begin
            stop_bad_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            stop_bad_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            stop_bad_q   <= stop_bad_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign o_parity_err = parity_err_q;
    assign o_frame_err  = frame_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: two instances (8E1 and 8N2) share one serial line and tick stream;
// a line-driven frame model predicts every output on every cycle.
`timescale 1ns/1ps
module tb_uart_rx_core;

    logic clock = 1'b0;
    logic rst_n;
    logic line;
    logic valid;
    logic checking;

    logic [8:0] o_data_a;
    logic       rx_done_a;
    logic [7:0] o_data_b;
    logic       rx_done_b;
`ifdef UART_RX_ERR_FLAGS_EN
    logic perr_a, ferr_a, perr_b, ferr_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt [2] = '{0, 0};

    // Model state: per configuration, ticks since start detection and sampled frame bits.
    int         m_busy [2];
    int         m_off  [2];
    logic       m_bits [2][16];
    logic       exp_done [2];
    logic [8:0] exp_word [2];
    logic       exp_perr [2];
    logic       exp_ferr [2];

    always #5 clock = ~clock;

    uart_rx_core #(
        .NB_DATA(1), .N_DATA(8), .LOG2_N_DATA(4), .PARITY_CHECK(1),
        .EVEN_ODD_PARITY(1), .M_STOP(1), .LOG2_M_STOP(1)
    ) dut_a (
        .i_clock(clock), .i_reset(rst_n), .i_data(line), .i_valid(valid),
        .o_data(o_data_a), .rx_done(rx_done_a)
`ifdef UART_RX_ERR_FLAGS_EN
        , .o_parity_err(perr_a), .o_frame_err(ferr_a)
`endif
    );

    uart_rx_core #(
        .NB_DATA(1), .N_DATA(8), .LOG2_N_DATA(4), .PARITY_CHECK(0),
        .EVEN_ODD_PARITY(1), .M_STOP(2), .LOG2_M_STOP(2)
    ) dut_b (
        .i_clock(clock), .i_reset(rst_n), .i_data(line), .i_valid(valid),
        .o_data(o_data_b), .rx_done(rx_done_b)
`ifdef UART_RX_ERR_FLAGS_EN
        , .o_parity_err(perr_b), .o_frame_err(ferr_b)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame length in bit slots after the start bit: 8E1 -> 8+1+1, 8N2 -> 8+0+2.
    function automatic int frameSlots(input int c);
        return (c == 0) ? 10 : 10;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            m_busy[c]   = 0;
            m_off[c]    = 0;
            exp_done[c] = 1'b0;
            exp_word[c] = '0;
            exp_perr[c] = 1'b0;
            exp_ferr[c] = 1'b0;
        end
    endtask

    task automatic modelFinish(input int c);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = m_bits[c][i];
        if (c == 0) begin
            exp_word[0] = {m_bits[0][8], d};
            exp_perr[0] = m_bits[0][8] ^ (^d);
            exp_ferr[0] = ~m_bits[0][9];
        end else begin
            exp_word[1] = {1'b0, d};
            exp_perr[1] = 1'b0;
            exp_ferr[1] = ~(m_bits[1][8] & m_bits[1][9]);
        end
        exp_done[c] = 1'b1;
    endtask

    // Start seen on a low tick; centre check 8 ticks later; then one sample every 16 ticks.
    task automatic modelTick();
        int k;
        for (int c = 0; c < 2; c++) begin
            if (m_busy[c] == 0) begin
                if (line == 1'b0) begin
                    m_busy[c] = 1;
                    m_off[c]  = 0;
                end
            end else begin
                m_off[c]++;
                if (m_off[c] == 8) begin
                    if (line) m_busy[c] = 0;
                end else if (m_off[c] > 8 && ((m_off[c] - 8) % 16) == 0) begin
                    k = (m_off[c] - 8) / 16;
                    m_bits[c][k-1] = line;
                    if (k == frameSlots(c)) begin
                        modelFinish(c);
                        m_busy[c] = 0;
                    end
                end
            end
        end
    endtask

    // One oversampling tick followed by a random tick-free gap; entered at posedge+1.
    task automatic tickOnce();
        int gap;
        gap   = $urandom_range(0, 2);
        valid = 1'b1;
        @(posedge clock); #1;
        valid = 1'b0;
        modelTick();
        @(posedge clock); #1;
        exp_done[0] = 1'b0;
        exp_done[1] = 1'b0;
        repeat (gap) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic holdLine(input logic v, input int n);
        line = v;
        repeat (n) tickOnce();
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit with_par, input logic par,
                                 input int n_stop, input logic stop_val, input int idle);
        holdLine(1'b0, 16);
        for (int i = 0; i < 8; i++) holdLine(data[i], 16);
        if (with_par) holdLine(par, 16);
        for (int s = 0; s < n_stop; s++) holdLine(stop_val, 16);
        line = 1'b1;
        if (idle > 0) holdLine(1'b1, idle);
    endtask

    // Per-cycle comparison of both instances against the model, away from the active edge.
    always @(negedge clock) begin
        if (rst_n && checking) begin
            checkOutput("rx_done_a", 32'(rx_done_a), 32'(exp_done[0]));
            checkOutput("o_data_a", 32'(o_data_a), 32'(exp_word[0]));
            checkOutput("rx_done_b", 32'(rx_done_b), 32'(exp_done[1]));
            checkOutput("o_data_b", 32'(o_data_b), 32'(exp_word[1][7:0]));
`ifdef UART_RX_ERR_FLAGS_EN
            checkOutput("parity_err_a", 32'(perr_a), 32'(exp_perr[0]));
            checkOutput("frame_err_a", 32'(ferr_a), 32'(exp_ferr[0]));
            checkOutput("parity_err_b", 32'(perr_b), 32'(exp_perr[1]));
            checkOutput("frame_err_b", 32'(ferr_b), 32'(exp_ferr[1]));
`endif
            if (rx_done_a === 1'b1) done_cnt[0]++;
            if (rx_done_b === 1'b1) done_cnt[1]++;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not complete within 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_a, base_b;
        logic [7:0] d;
        logic [7:0] a5;

        rst_n    = 1'b0;
        valid    = 1'b0;
        line     = 1'b1;
        checking = 1'b0;
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset o_data_a", 32'(o_data_a), 32'h0);
        checkOutput("reset rx_done_a", 32'(rx_done_a), 32'h0);
        checkOutput("reset o_data_b", 32'(o_data_b), 32'h0);
        checkOutput("reset rx_done_b", 32'(rx_done_b), 32'h0);
        rst_n    = 1'b1;
        checking = 1'b1;
        @(posedge clock); #1;
        holdLine(1'b1, 20);

        // 0x77, parity 0, then 0x90 with parity 1 straight after the stop bit.
        base_a = done_cnt[0];
        applyStimulus(8'h77, 1'b1, 1'b0, 1, 1'b1, 0);
        checkOutput("0x77 done pulses", 32'(done_cnt[0] - base_a), 32'd1);
        checkOutput("0x77 o_data", 32'(o_data_a), 32'h077);
        checkOutput("0x77 model word", 32'(exp_word[0]), 32'h077);
`ifdef UART_RX_ERR_FLAGS_EN
        checkOutput("0x77 parity_err", 32'(perr_a), 32'h0);
`endif
        base_a = done_cnt[0];
        applyStimulus(8'h90, 1'b1, 1'b1, 1, 1'b1, 20);
        checkOutput("0x90 done pulses", 32'(done_cnt[0] - base_a), 32'd1);
        checkOutput("0x90 o_data", 32'(o_data_a), 32'h190);
        checkOutput("0x90 model word", 32'(exp_word[0]), 32'h190);
`ifdef UART_RX_ERR_FLAGS_EN
        checkOutput("0x90 parity_err", 32'(perr_a), 32'h1);
        checkOutput("0x90 model parity_err", 32'(exp_perr[0]), 32'h1);
`endif

        // Start-bit glitch: four low ticks, then idle.
        base_a = done_cnt[0];
        holdLine(1'b0, 4);
        holdLine(1'b1, 30);
        checkOutput("glitch done pulses", 32'(done_cnt[0] - base_a), 32'd0);
        checkOutput("glitch o_data held", 32'(o_data_a), 32'h190);

        // 0x55 with a low stop bit still completes.
        base_a = done_cnt[0];
        applyStimulus(8'h55, 1'b1, 1'b0, 1, 1'b0, 30);
        checkOutput("0x55 done pulses", 32'(done_cnt[0] - base_a), 32'd1);
        checkOutput("0x55 o_data", 32'(o_data_a), 32'h055);
`ifdef UART_RX_ERR_FLAGS_EN
        checkOutput("0x55 frame_err", 32'(ferr_a), 32'h1);
        checkOutput("0x55 parity_err", 32'(perr_a), 32'h0);
`endif

        // Reset in the middle of the data bits of 0xA5, then a clean 0x3C.
        base_a = done_cnt[0];
        a5 = 8'hA5;
        holdLine(1'b0, 16);
        for (int i = 0; i < 3; i++) holdLine(a5[i], 16);
        holdLine(a5[3], 5);
        rst_n = 1'b0;
        line  = 1'b1;
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        checkOutput("mid-frame reset o_data_a", 32'(o_data_a), 32'h0);
        checkOutput("mid-frame reset rx_done_a", 32'(rx_done_a), 32'h0);
        rst_n = 1'b1;
        @(posedge clock); #1;
        holdLine(1'b1, 20);
        checkOutput("after reset done pulses", 32'(done_cnt[0] - base_a), 32'd0);
        checkOutput("after reset o_data_a", 32'(o_data_a), 32'h0);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1, 1'b1, 20);
        checkOutput("0x3C done pulses", 32'(done_cnt[0] - base_a), 32'd1);
        checkOutput("0x3C o_data", 32'(o_data_a), 32'h03C);

        // 8N2 frame for the second instance.
        base_b = done_cnt[1];
        applyStimulus(8'hC3, 1'b0, 1'b0, 2, 1'b1, 30);
        checkOutput("0xC3 8N2 done pulses", 32'(done_cnt[1] - base_b), 32'd1);
        checkOutput("0xC3 8N2 o_data", 32'(o_data_b), 32'hC3);
        checkOutput("0xC3 model word", 32'(exp_word[1]), 32'h0C3);

        // Randomized frames and glitches; the per-cycle compare does the checking.
        for (int n = 0; n < 10; n++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                holdLine(1'b0, $urandom_range(1, 7));
                holdLine(1'b1, $urandom_range(1, 12));
            end
            applyStimulus(d, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? ~^d : ^d,
                          $urandom_range(1, 2),
                          1'($urandom_range(0, 4) != 0),
                          $urandom_range(0, 20));
        end
        holdLine(1'b1, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
